// File: rtl/systolic_2x2_ctrl_if.sv
// Host register bus of the 2x2 systolic sequencer.
// master = host side, slave = sequencer side.
interface systolic_2x2_ctrl_if #(
   parameter int WIDTH = 8
);
   logic                 load_en;
   logic [2:0]           load_sel;
   logic [WIDTH-1:0]     load_data;
   logic                 start;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   res_c00;
   logic [2*WIDTH-1:0]   res_c01;
   logic [2*WIDTH-1:0]   res_c10;
   logic [2*WIDTH-1:0]   res_c11;
   logic [15:0]          op_count;

   modport master (
      output load_en, load_sel, load_data, start,
      input  busy, done,
      input  res_c00, res_c01, res_c10, res_c11,
      input  op_count
   );

   modport slave (
      input  load_en, load_sel, load_data, start,
      output busy, done,
      output res_c00, res_c01, res_c10, res_c11,
      output op_count
   );
endinterface

// File: rtl/systolic_2x2_ctrl.sv
// Clear/skew-feed/drain/capture sequencer for a 2x2 systolic array.
// SYSTOLIC_CTRL_PERFCNT_EN builds the completed-run counter on op_count.
module systolic_2x2_ctrl #(
   parameter int WIDTH = 8,
   parameter int DRAIN = 3
) (
   input  logic                clk,
   input  logic                rst,
   systolic_2x2_ctrl_if.slave  host,
   output logic                arr_clear,
   output logic [WIDTH-1:0]    arr_a0,
   output logic [WIDTH-1:0]    arr_a1,
   output logic [WIDTH-1:0]    arr_b0,
   output logic [WIDTH-1:0]    arr_b1,
   input  logic [2*WIDTH-1:0]  arr_c00,
   input  logic [2*WIDTH-1:0]  arr_c01,
   input  logic [2*WIDTH-1:0]  arr_c10,
   input  logic [2*WIDTH-1:0]  arr_c11
);
   localparam int RW = 2 * WIDTH;
   localparam logic [3:0] DRAIN_LAST = 4'(DRAIN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_DRAIN,
      S_CAPTURE
   } state_e;

   state_e                    state_q, state_d;
   logic [3:0]                cnt_q, cnt_d;
   logic [3:0][WIDTH-1:0]     a_q, a_d;
   logic [3:0][WIDTH-1:0]     b_q, b_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      clear_q, clear_d;
   logic [WIDTH-1:0]          a0_q, a0_d;
   logic [WIDTH-1:0]          a1_q, a1_d;
   logic [WIDTH-1:0]          b0_q, b0_d;
   logic [WIDTH-1:0]          b1_q, b1_d;
   logic [RW-1:0]             c00_q, c00_d;
   logic [RW-1:0]             c01_q, c01_d;
   logic [RW-1:0]             c10_q, c10_d;
   logic [RW-1:0]             c11_q, c11_d;

   // Edge data is computed one cycle early so every arr_* output is a flop.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      done_d  = 1'b0;
      clear_d = 1'b0;
      a0_d    = '0;
      a1_d    = '0;
      b0_d    = '0;
      b1_d    = '0;
      c00_d   = c00_q;
      c01_d   = c01_q;
      c10_d   = c10_q;
      c11_d   = c11_q;
      unique case (state_q)
         S_IDLE: begin
            if (host.load_en) begin
               if (host.load_sel[2]) begin
                  b_d[host.load_sel[1:0]] = host.load_data;
               end else begin
                  a_d[host.load_sel[1:0]] = host.load_data;
               end
            end
            if (host.start) begin
               state_d = S_CLEAR;
               clear_d = 1'b1;
            end
         end
         S_CLEAR: begin
            state_d = S_FEED;
            cnt_d   = '0;
            a0_d    = a_d[0];
            b0_d    = b_d[0];
         end
         S_FEED: begin
            cnt_d = cnt_q + 4'd1;
            case (cnt_q[1:0])
               2'd0: begin
                  a0_d = a_q[1];
                  a1_d = a_q[2];
                  b0_d = b_q[2];
                  b1_d = b_q[1];
               end
               2'd1: begin
                  a1_d = a_q[3];
                  b1_d = b_q[3];
               end
               default: begin
                  state_d = S_DRAIN;
                  cnt_d   = '0;
               end
            endcase
         end
         S_DRAIN: begin
            if (cnt_q == DRAIN_LAST) begin
               state_d = S_CAPTURE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_CAPTURE: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            c00_d   = arr_c00;
            c01_d   = arr_c01;
            c10_d   = arr_c10;
            c11_d   = arr_c11;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         clear_q <= 1'b0;
         a0_q    <= '0;
         a1_q    <= '0;
         b0_q    <= '0;
         b1_q    <= '0;
         c00_q   <= '0;
         c01_q   <= '0;
         c10_q   <= '0;
         c11_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         clear_q <= clear_d;
         a0_q    <= a0_d;
         a1_q    <= a1_d;
         b0_q    <= b0_d;
         b1_q    <= b1_d;
         c00_q   <= c00_d;
         c01_q   <= c01_d;
         c10_q   <= c10_d;
         c11_q   <= c11_d;
      end
   end

`ifdef SYSTOLIC_CTRL_PERFCNT_EN
   logic [15:0] op_count_q, op_count_d;

   always_comb begin
      op_count_d = op_count_q + 16'(done_d);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_count_q <= '0;
      end else begin
         op_count_q <= op_count_d;
      end
   end

   assign host.op_count = op_count_q;
`else
   assign host.op_count = '0;
`endif

   assign host.busy    = busy_q;
   assign host.done    = done_q;
   assign host.res_c00 = c00_q;
   assign host.res_c01 = c01_q;
   assign host.res_c10 = c10_q;
   assign host.res_c11 = c11_q;
   assign arr_clear    = clear_q;
   assign arr_a0       = a0_q;
   assign arr_a1       = a1_q;
   assign arr_b0       = b0_q;
   assign arr_b1       = b1_q;
endmodule

// File: tb/tb_systolic_2x2_ctrl.sv
// Directed bench for systolic_2x2_ctrl driving a behavioural 2x2 array.
// Build with SYSTOLIC_CTRL_PERFCNT_EN to exercise the run counter.
module tb_systolic_2x2_ctrl;
   localparam int W  = 8;
   localparam int RW = 2 * W;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   systolic_2x2_ctrl_if #(.WIDTH(W)) hif ();

   logic          arr_clear;
   logic [W-1:0]  arr_a0, arr_a1, arr_b0, arr_b1;
   logic [RW-1:0] arr_c00 = '0;
   logic [RW-1:0] arr_c01 = '0;
   logic [RW-1:0] arr_c10 = '0;
   logic [RW-1:0] arr_c11 = '0;
   logic [W-1:0]  ar0 = '0;
   logic [W-1:0]  ar1 = '0;
   logic [W-1:0]  bc0 = '0;
   logic [W-1:0]  bc1 = '0;

   systolic_2x2_ctrl #(.WIDTH(W), .DRAIN(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .host      (hif),
      .arr_clear (arr_clear),
      .arr_a0    (arr_a0),
      .arr_a1    (arr_a1),
      .arr_b0    (arr_b0),
      .arr_b1    (arr_b1),
      .arr_c00   (arr_c00),
      .arr_c01   (arr_c01),
      .arr_c10   (arr_c10),
      .arr_c11   (arr_c11)
   );

   // Output-stationary PEs: a moves right, b moves down, one cycle per hop.
   always @(posedge clk) begin
      if (arr_clear) begin
         arr_c00 <= '0;
         arr_c01 <= '0;
         arr_c10 <= '0;
         arr_c11 <= '0;
         ar0     <= '0;
         ar1     <= '0;
         bc0     <= '0;
         bc1     <= '0;
      end else begin
         arr_c00 <= arr_c00 + RW'(arr_a0) * RW'(arr_b0);
         arr_c01 <= arr_c01 + RW'(ar0) * RW'(arr_b1);
         arr_c10 <= arr_c10 + RW'(arr_a1) * RW'(bc0);
         arr_c11 <= arr_c11 + RW'(ar1) * RW'(bc1);
         ar0     <= arr_a0;
         ar1     <= arr_a1;
         bc0     <= arr_b0;
         bc1     <= arr_b1;
      end
   end

   logic [63:0] arr_w;
   logic [63:0] res_w;
   assign arr_w = 64'({arr_clear, arr_a0, arr_a1, arr_b0, arr_b1});
   assign res_w = {hif.res_c00, hif.res_c01, hif.res_c10, hif.res_c11};

   int npass = 0;
   int nchk  = 0;
   int ndone;
   int dcyc;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp_v);
      nchk = nchk + 1;
      assert (obs === exp_v) npass = npass + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
   endtask

   function automatic logic [63:0] opc(input int n);
`ifdef SYSTOLIC_CTRL_PERFCNT_EN
      return 64'(n);
`else
      return 64'(n * 0);
`endif
   endfunction

   task automatic load(input logic [2:0] sel, input logic [7:0] dat);
      hif.load_en   = 1'b1;
      hif.load_sel  = sel;
      hif.load_data = dat;
      @(negedge clk);
      hif.load_en   = 1'b0;
   endtask

   // Starts a run in the current cycle; leaves the bench in the done cycle.
   task automatic go_run(input logic ld, input logic [2:0] sel,
                         input logic [7:0] dat, input string tag,
                         input logic [63:0] exp_res);
      int cyc;
      hif.load_en   = ld;
      hif.load_sel  = sel;
      hif.load_data = dat;
      hif.start     = 1'b1;
      @(negedge clk);
      hif.load_en = 1'b0;
      hif.start   = 1'b0;
      cyc = 1;
      while (!hif.done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_lat"}, 64'(cyc), 64'd9);
      chk({tag, "_res"}, res_w, exp_res);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b0;
      hif.load_en   = 1'b0;
      hif.load_sel  = 3'd0;
      hif.load_data = 8'd0;
      hif.start     = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(hif.busy), 64'd0);
      chk("rst_done", 64'(hif.done), 64'd0);
      chk("rst_arr", arr_w, 64'd0);
      chk("rst_res", res_w, 64'd0);
      chk("rst_opc", 64'(hif.op_count), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      load(3'd0, 8'd1); load(3'd1, 8'd2);
      load(3'd2, 8'd3); load(3'd3, 8'd4);
      load(3'd4, 8'd5); load(3'd5, 8'd6);
      load(3'd6, 8'd7); load(3'd7, 8'd8);

      hif.start = 1'b1;
      @(negedge clk);
      hif.start = 1'b0;
      chk("t1_arr", arr_w, 64'({1'b1, 32'h0}));
      chk("t1_busy", 64'(hif.busy), 64'd1);
      @(negedge clk);
      chk("t2_arr", arr_w, 64'({1'b0, 8'd1, 8'd0, 8'd5, 8'd0}));
      @(negedge clk);
      chk("t3_arr", arr_w, 64'({1'b0, 8'd2, 8'd3, 8'd7, 8'd6}));
      @(negedge clk);
      chk("t4_arr", arr_w, 64'({1'b0, 8'd0, 8'd4, 8'd0, 8'd8}));
      for (int k = 5; k <= 7; k++) begin
         @(negedge clk);
         chk($sformatf("t%0d_arr", k), arr_w, 64'd0);
         chk($sformatf("t%0d_busy", k), 64'(hif.busy), 64'd1);
      end
      @(negedge clk);
      chk("t8_busy", 64'(hif.busy), 64'd1);
      chk("t8_done", 64'(hif.done), 64'd0);
      @(negedge clk);
      chk("t9_done", 64'(hif.done), 64'd1);
      chk("t9_busy", 64'(hif.busy), 64'd0);
      chk("t9_res", res_w, {16'd19, 16'd22, 16'd43, 16'd50});
      chk("t9_opc", 64'(hif.op_count), opc(1));

      // Back-to-back run with start pulses and an A00 write while busy.
      ndone = 0;
      dcyc  = 0;
      hif.start = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (hif.done) begin
            ndone++;
            dcyc = i;
         end
         hif.start     = (i <= 7);
         hif.load_en   = (i >= 2 && i <= 4);
         hif.load_sel  = 3'd0;
         hif.load_data = 8'd9;
      end
      hif.start   = 1'b0;
      hif.load_en = 1'b0;
      chk("lock_ndone", 64'(ndone), 64'd1);
      chk("lock_dcyc", 64'(dcyc), 64'd9);
      chk("lock_res", res_w, {16'd19, 16'd22, 16'd43, 16'd50});

      load(3'd4, 8'd1); load(3'd5, 8'd0); load(3'd6, 8'd0);
      go_run(1'b0, 3'd0, 8'd0, "run3", {16'd1, 16'd16, 16'd3, 16'd32});
      chk("run3_opc", 64'(hif.op_count), opc(3));

      go_run(1'b1, 3'd7, 8'd1, "b2b", {16'd1, 16'd2, 16'd3, 16'd4});
      chk("b2b_opc", 64'(hif.op_count), opc(4));

      // Reset asserted between edges during FEED step 1.
      hif.start = 1'b1;
      @(negedge clk);
      hif.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("mrst_busy", 64'(hif.busy), 64'd0);
      chk("mrst_done", 64'(hif.done), 64'd0);
      chk("mrst_arr", arr_w, 64'd0);
      chk("mrst_res", res_w, 64'd0);
      chk("mrst_opc", 64'(hif.op_count), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("post_busy", 64'(hif.busy), 64'd0);

      load(3'd0, 8'd2); load(3'd1, 8'd3);
      load(3'd2, 8'd4); load(3'd3, 8'd5);
      load(3'd4, 8'd1); load(3'd5, 8'd2);
      load(3'd6, 8'd3); load(3'd7, 8'd4);
      go_run(1'b0, 3'd0, 8'd0, "fresh", {16'd11, 16'd16, 16'd19, 16'd28});
      chk("fresh_opc", 64'(hif.op_count), opc(1));

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
